// File: rtl/text_writer_pkg.sv
// text_writer_pkg: geometry, character codes and FSM state encoding
// shared by the text_writer write-port controller and the display side.
package text_writer_pkg;

    localparam int DEF_COLS  = 40;
    localparam int DEF_ROWS  = 30;
    localparam int DEF_COL_W = 6;
    localparam int DEF_ROW_W = 5;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;

    typedef enum logic [1:0] {
        ST_CLEAR      = 2'd0,
        ST_IDLE       = 2'd1,
        ST_LINE_CLEAR = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// text_writer_if: byte-stream valid/ready handshake into text_writer.
// master = byte source, slave = text_writer.
interface text_writer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/text_cursor.sv
// text_cursor: row/col cursor with wrap. Ports: i_advance (col+1),
// i_newline (col 0 + row advance), i_cr, i_backspace, i_home; o_col,
// o_row, o_wrap (this cycle's command causes a row advance).
module text_cursor
    import text_writer_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    input  logic             i_newline,
    input  logic             i_cr,
    input  logic             i_backspace,
    input  logic             i_home,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_wrap
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_wrap;

    assign w_wrap = (i_advance && (r_col == LAST_COL)) || i_newline;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_wrap) begin
            r_col <= '0;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
        end else if (i_advance) begin
            r_col <= r_col + COL_W'(1);
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_backspace && (r_col != '0)) begin
            r_col <= r_col - COL_W'(1);
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_wrap = w_wrap;

endmodule

// File: rtl/text_writer.sv
// text_writer: byte stream -> text RAM write port with cursor and clears.
// Ports: clk, rst, bus (slave), clear; waddr/wdata/write_en, cursor, busy.
module text_writer
    import text_writer_pkg::*;
#(
    parameter int         COLS  = DEF_COLS,
    parameter int         ROWS  = DEF_ROWS,
    parameter int         COL_W = DEF_COL_W,
    parameter int         ROW_W = DEF_ROW_W,
    parameter logic [7:0] FILL  = CHAR_SPACE
) (
    input  logic                   clk,
    input  logic                   rst,
    text_writer_if.slave           bus,
    input  logic                   clear,
    output logic [ROW_W+COL_W-1:0] waddr,
    output logic [7:0]             wdata,
    output logic                   write_en,
    output logic [COL_W-1:0]       cursor_col,
    output logic [ROW_W-1:0]       cursor_row,
    output logic                   busy
);

    localparam int               AW       = ROW_W + COL_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           r_state;
    logic [COL_W-1:0] r_fill_col;
    logic [ROW_W-1:0] r_fill_row;
    logic             r_fill_done;
    logic             r_busy;
    logic             r_we;
    logic [AW-1:0]    r_waddr;
    logic [7:0]       r_wdata;

    logic [COL_W-1:0] w_col;
    logic [COL_W-1:0] w_col_m1;
    logic [ROW_W-1:0] w_row;
    logic             w_wrap;
    logic             w_ready;
    logic             w_accept;
    logic             w_print;
    logic             w_lf;
    logic             w_cr;
    logic             w_bs;
    logic             w_ff;
    logic             w_restart;

    assign w_ready   = (r_state == ST_IDLE) && !clear;
    assign w_accept  = bus.in_valid && w_ready;
    assign w_print   = w_accept && is_printable(bus.in_data);
    assign w_lf      = w_accept && (bus.in_data == CHAR_LF);
    assign w_cr      = w_accept && (bus.in_data == CHAR_CR);
    assign w_bs      = w_accept && (bus.in_data == CHAR_BS);
    assign w_ff      = w_accept && (bus.in_data == CHAR_FF);
    assign w_restart = clear || w_ff;
    assign w_col_m1  = w_col - COL_W'(1);

    text_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_print),
        .i_newline   (w_lf),
        .i_cr        (w_cr),
        .i_backspace (w_bs),
        .i_home      (w_restart),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_wrap      (w_wrap)
    );

    // r_fill_done holds CLEAR for one cycle after the last fill write so
    // busy stays high through that write and in_ready rises with busy low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_fill_col  <= '0;
            r_fill_row  <= '0;
            r_fill_done <= 1'b0;
            r_busy      <= 1'b1;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_restart) begin
                r_state     <= ST_CLEAR;
                r_fill_col  <= '0;
                r_fill_row  <= '0;
                r_fill_done <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                unique case (r_state)
                    ST_CLEAR: begin
                        if (r_fill_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_we    <= 1'b1;
                            r_waddr <= {r_fill_row, r_fill_col};
                            r_wdata <= FILL;
                            if (r_fill_col == LAST_COL) begin
                                r_fill_col <= '0;
                                if (r_fill_row == LAST_ROW)
                                    r_fill_done <= 1'b1;
                                else
                                    r_fill_row <= r_fill_row + ROW_W'(1);
                            end else begin
                                r_fill_col <= r_fill_col + COL_W'(1);
                            end
                        end
                    end
                    ST_IDLE: begin
                        if (w_print) begin
                            r_we    <= 1'b1;
                            r_waddr <= {w_row, w_col};
                            r_wdata <= bus.in_data;
                        end else if (w_bs && (w_col != '0)) begin
                            r_we    <= 1'b1;
                            r_waddr <= {w_row, w_col_m1};
                            r_wdata <= FILL;
                        end
                        if (w_wrap) begin
                            r_state    <= ST_LINE_CLEAR;
                            r_fill_col <= '0;
                        end
                    end
                    ST_LINE_CLEAR: begin
                        // cursor row has already advanced to the new row
                        r_we    <= 1'b1;
                        r_waddr <= {w_row, r_fill_col};
                        r_wdata <= FILL;
                        if (r_fill_col == LAST_COL)
                            r_state <= ST_IDLE;
                        else
                            r_fill_col <= r_fill_col + COL_W'(1);
                    end
                    default: begin
                        r_state <= ST_CLEAR;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready = w_ready;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign write_en     = r_we;
    assign cursor_col   = w_col;
    assign cursor_row   = w_row;
    assign busy         = r_busy;

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed scenario tasks for text_writer with inline
// comparisons against hand-computed addresses, data and cursor values.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic        write_en;
    logic [5:0]  ccol;
    logic [4:0]  crow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    text_writer_if bus();

    text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear      (clear),
        .waddr      (waddr),
        .wdata      (wdata),
        .write_en   (write_en),
        .cursor_col (ccol),
        .cursor_row (crow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe a full clear: counts writes, bad addr/data, busy drops.
    task automatic wait_clear(output int n, output int bad,
                              output int busy_bad);
        logic [10:0] exp;
        n = 0;
        bad = 0;
        busy_bad = 0;
        for (int k = 0; k < 1400; k++) begin
            tick();
            if (write_en === 1'b1) begin
                exp = {5'(n / 40), 6'(n % 40)};
                if (waddr !== exp || wdata !== 8'h20) bad++;
                if (busy !== 1'b1) busy_bad++;
                n++;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n, bad, bb;
        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        #1;
        checks++;
        if (write_en !== 1'b0 || waddr !== 11'h0 || wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_wr: we=%b a=%h d=%h want 0/0/0",
                     write_en, waddr, wdata);
        end
        checks++;
        if (ccol !== 6'd0 || crow !== 5'd0) begin
            errors++;
            $display("FAIL reset_cur: got %0d,%0d want 0,0", crow, ccol);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: rdy=%b busy=%b want 0/1",
                     bus.in_ready, busy);
        end
        repeat (3) tick();
        rst = 1'b0;
        wait_clear(n, bad, bb);
        checks++;
        if (n !== 1200 || bad !== 0 || bb !== 0) begin
            errors++;
            $display("FAIL init_clear: n=%0d bad=%0d bb=%0d want 1200/0/0",
                     n, bad, bb);
        end
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            ccol !== 6'd0 || crow !== 5'd0) begin
            errors++;
            $display("FAIL init_done: busy=%b rdy=%b cur=%0d,%0d want 0/1/0,0",
                     busy, bus.in_ready, crow, ccol);
        end
    endtask

    task automatic test_char();
        bus.in_data = 8'h41;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (write_en !== 1'b1 || waddr !== 11'h000 || wdata !== 8'h41 ||
            ccol !== 6'd1) begin
            errors++;
            $display("FAIL char_A: we=%b a=%h d=%h col=%0d want 1/000/41/1",
                     write_en, waddr, wdata, ccol);
        end
        tick();
        checks++;
        if (write_en !== 1'b0) begin
            errors++;
            $display("FAIL char_strobe: we=%b want 0", write_en);
        end
    endtask

    task automatic test_full_row();
        int bad = 0;
        logic [7:0] b;
        bus.in_data = 8'h0D;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (write_en !== 1'b0 || ccol !== 6'd0) begin
            errors++;
            $display("FAIL cr: we=%b col=%0d want 0/0", write_en, ccol);
        end
        for (int i = 0; i < 40; i++) begin
            b = 8'(8'h41 + (i % 26));
            bus.in_data = b;
            tick();
            if (write_en !== 1'b1 || waddr !== 11'(i) || wdata !== b)
                bad++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL row_writes: bad=%0d want 0", bad);
        end
        checks++;
        if (crow !== 5'd1 || ccol !== 6'd0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL row_wrap: cur=%0d,%0d rdy=%b want 1,0 rdy 0",
                     crow, ccol, bus.in_ready);
        end
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (write_en !== 1'b1 || waddr !== 11'(12'h040 + j) ||
                wdata !== 8'h20 || bus.in_ready !== (j == 39))
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL line_clear: bad=%0d want 0", bad);
        end
        tick();
        checks++;
        if (write_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL line_done: we=%b rdy=%b want 0/1",
                     write_en, bus.in_ready);
        end
    endtask

    task automatic test_backspace();
        bus.in_data = 8'h08;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (write_en !== 1'b0 || ccol !== 6'd0 || crow !== 5'd1) begin
            errors++;
            $display("FAIL bs_col0: we=%b cur=%0d,%0d want 0 1,0",
                     write_en, crow, ccol);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'h61;
            tick();
        end
        bus.in_data = 8'h08;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (write_en !== 1'b1 || waddr !== 11'h044 || wdata !== 8'h20 ||
            ccol !== 6'd4) begin
            errors++;
            $display("FAIL bs_col5: we=%b a=%h d=%h col=%0d want 1/044/20/4",
                     write_en, waddr, wdata, ccol);
        end
        tick();
    endtask

    task automatic test_lf_wrap();
        int to = 0;
        int bad = 0;
        for (int i = 0; i < 40 && crow !== 5'd29; i++) begin
            bus.in_data = 8'h0A;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            begin : wait_rdy
                for (int k = 0; k < 60; k++) begin
                    if (bus.in_ready === 1'b1) disable wait_rdy;
                    tick();
                end
                to++;
            end
        end
        checks++;
        if (crow !== 5'd29 || to !== 0) begin
            errors++;
            $display("FAIL lf_reach29: row=%0d timeouts=%0d want 29/0",
                     crow, to);
        end
        bus.in_data = 8'h0A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (crow !== 5'd0 || ccol !== 6'd0 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL lf_wrap: cur=%0d,%0d we=%b want 0,0 we 0",
                     crow, ccol, write_en);
        end
        for (int j = 0; j < 40; j++) begin
            tick();
            if (write_en !== 1'b1 || waddr !== 11'(j) || wdata !== 8'h20)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lf_row0_fill: bad=%0d want 0", bad);
        end
    endtask

    task automatic test_clear_collision();
        int n, bad, bb;
        bus.in_data = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (ccol !== 6'd1) begin
            errors++;
            $display("FAIL pre_col: col=%0d want 1", ccol);
        end
        bus.in_data = 8'h41;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (write_en !== 1'b0 || ccol !== 6'd0 || busy !== 1'b1 ||
            bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL collide: we=%b col=%0d busy=%b rdy=%b want 0/0/1/0",
                     write_en, ccol, busy, bus.in_ready);
        end
        wait_clear(n, bad, bb);
        checks++;
        if (n !== 1200 || bad !== 0 || bb !== 0 || busy !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_clear: n=%0d bad=%0d bb=%0d busy=%b rdy=%b",
                     n, bad, bb, busy, bus.in_ready);
        end
    endtask

    task automatic test_clear_mid_line();
        int n, bad, bb;
        bus.in_data = 8'h0A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (write_en !== 1'b1 || bus.in_ready !== 1'b0 ||
            waddr !== 11'h044) begin
            errors++;
            $display("FAIL mid_line: we=%b rdy=%b a=%h want 1/0/044",
                     write_en, bus.in_ready, waddr);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (write_en !== 1'b0 || busy !== 1'b1 || crow !== 5'd0) begin
            errors++;
            $display("FAIL mid_abort: we=%b busy=%b row=%0d want 0/1/0",
                     write_en, busy, crow);
        end
        wait_clear(n, bad, bb);
        checks++;
        if (n !== 1200 || bad !== 0 || bb !== 0) begin
            errors++;
            $display("FAIL mid_clear: n=%0d bad=%0d bb=%0d want 1200/0/0",
                     n, bad, bb);
        end
    endtask

    task automatic test_ff();
        int n, bad, bb;
        bus.in_data = 8'h0C;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (write_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ff: we=%b busy=%b want 0/1", write_en, busy);
        end
        wait_clear(n, bad, bb);
        checks++;
        if (n !== 1200 || bad !== 0 || bb !== 0) begin
            errors++;
            $display("FAIL ff_clear: n=%0d bad=%0d bb=%0d want 1200/0/0",
                     n, bad, bb);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad, bb;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (100) tick();
        checks++;
        if (write_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: we=%b busy=%b want 1/1", write_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (write_en !== 1'b0 || waddr !== 11'h0 || busy !== 1'b1 ||
            bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: we=%b a=%h busy=%b rdy=%b want 0/0/1/0",
                     write_en, waddr, busy, bus.in_ready);
        end
        tick();
        rst = 1'b0;
        wait_clear(n, bad, bb);
        checks++;
        if (n !== 1200 || bad !== 0 || bb !== 0) begin
            errors++;
            $display("FAIL rst_restart: n=%0d bad=%0d bb=%0d want 1200/0/0",
                     n, bad, bb);
        end
    endtask

    initial begin
        test_reset();
        test_char();
        test_full_row();
        test_backspace();
        test_lf_wrap();
        test_clear_collision();
        test_clear_mid_line();
        test_ff();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
